genius_game_controller: RTL and testbench

Top-level sequencer for the Genius (Simon) game. Consumes the single-cycle rising-edge pulses from the button edge detector, generates a growing pseudo-random colour sequence, plays it back on the four LEDs with fixed on/off timing, checks the player's replay, and reports level, win and lose. Sits between the button edge detector and the LED/display drivers.

---
 rtl/genius_pkg.sv | 35 +++
 rtl/genius_lfsr.sv | 19 +
 rtl/genius_game_controller.sv | 160 ++++++++++++++++
 tb/tb_genius_game_controller.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/genius_pkg.sv
// Shared types and helpers for the Genius (Simon) game controller.
package genius_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    RED    = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } color_t;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SHOW_ON,
    SHOW_OFF,
    WAIT_IN,
    WIN,
    LOSE
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Colour code to LED/button bit position.
  function automatic logic [3:0] onehot(input color_t c);
    logic [3:0] v;
    case (c)
      GREEN:   v = 4'b0001;
      RED:     v = 4'b0010;
      BLUE:    v = 4'b0100;
      default: v = 4'b1000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/genius_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the colour source.
module genius_lfsr
  import genius_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] out
);

  logic feedback;

  assign feedback = out[0] ^ out[2] ^ out[3] ^ out[5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= LFSR_SEED;
    else        out <= {feedback, out[15:1]};
  end

endmodule

// File: rtl/genius_game_controller.sv
// Genius/Simon sequencer: grows a random colour sequence, plays it back on the
// LEDs, checks the player's replay and reports level, win and lose.
module genius_game_controller
  import genius_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned LED_ON_CYCLES  = 25_000_000,
  parameter int unsigned LED_OFF_CYCLES = 12_500_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] btn_edge,
  output logic [3:0] led,
  output logic [5:0] level,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  localparam int unsigned SHOW_MAX = (LED_ON_CYCLES > LED_OFF_CYCLES) ? LED_ON_CYCLES : LED_OFF_CYCLES;
  localparam int unsigned CNT_MAX  = (SHOW_MAX > TIMEOUT_CYCLES) ? SHOW_MAX : TIMEOUT_CYCLES;
  localparam int unsigned CW       = $clog2(CNT_MAX);
  localparam int unsigned IW       = $clog2(MAX_LEN);

  localparam logic [CW-1:0] ON_LAST   = CW'(LED_ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LAST  = CW'(LED_OFF_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]    MAX_LEN_V = 6'(MAX_LEN);

  state_t          state, state_d;
  logic [5:0]      len, len_d;
  logic [5:0]      idx, idx_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [3:0]      led_d;
  logic            busy_d, win_d, lose_d;
  logic            seq_we;
  color_t          seq [MAX_LEN];
  color_t          new_color, exp_color, show_color;
  logic [15:0]     lfsr;
  logic            unused_lfsr;

  genius_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (lfsr)
  );

  assign new_color   = color_t'(lfsr[1:0]);
  assign unused_lfsr = ^lfsr[15:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      len   <= '0;
      idx   <= '0;
      cnt   <= '0;
      led   <= '0;
      level <= '0;
      busy  <= 1'b0;
      win   <= 1'b0;
      lose  <= 1'b0;
    end else begin
      state <= state_d;
      len   <= len_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
      led   <= led_d;
      level <= len_d;
      busy  <= busy_d;
      win   <= win_d;
      lose  <= lose_d;
    end
  end

  // Sequence memory is not reset; only entries below len are ever read.
  always_ff @(posedge clk) begin
    if (seq_we) seq[len[IW-1:0]] <= new_color;
  end

  always_comb begin
    state_d   = state;
    len_d     = len;
    idx_d     = idx;
    cnt_d     = cnt;
    seq_we    = 1'b0;
    exp_color = seq[idx[IW-1:0]];

    case (state)
      IDLE, WIN, LOSE: begin
        if (start) begin
          len_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        seq_we  = 1'b1;
        len_d   = len + 6'd1;
        idx_d   = '0;
        cnt_d   = '0;
        state_d = SHOW_ON;
      end
      SHOW_ON: begin
        if (cnt == ON_LAST) begin
          cnt_d   = '0;
          state_d = SHOW_OFF;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      SHOW_OFF: begin
        if (cnt == OFF_LAST) begin
          cnt_d = '0;
          if (idx == len - 6'd1) begin
            idx_d   = '0;
            state_d = WAIT_IN;
          end else begin
            idx_d   = idx + 6'd1;
            state_d = SHOW_ON;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      WAIT_IN: begin
        // A press in the timeout's last cycle takes precedence over the timeout.
        if (btn_edge != 4'b0000) begin
          if (btn_edge == onehot(exp_color)) begin
            if (idx == len - 6'd1) begin
              state_d = (len == MAX_LEN_V) ? WIN : ADD;
            end else begin
              idx_d = idx + 6'd1;
              cnt_d = '0;
            end
          end else begin
            state_d = LOSE;
          end
        end else if (cnt == TO_LAST) begin
          state_d = LOSE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // First colour of a new game is being written this cycle, so bypass memory.
    show_color = (state == ADD && len == 6'd0) ? new_color : seq[idx_d[IW-1:0]];

    led_d = 4'b0000;
    if (state_d == SHOW_ON)  led_d = onehot(show_color);
    else if (state_d == WIN) led_d = 4'b1111;

    busy_d = !(state_d inside {IDLE, WIN, LOSE});
    win_d  = (state_d == WIN);
    lose_d = (state_d == LOSE);
  end

endmodule

// File: tb/tb_genius_game_controller.sv
// Self-checking bench for genius_game_controller with short timing parameters.
module tb_genius_game_controller;
  import genius_pkg::*;

  localparam int unsigned MAX_LEN = 3;
  localparam int unsigned ON      = 4;
  localparam int unsigned OFF     = 2;
  localparam int unsigned TO      = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] btn_edge = 4'b0000;
  logic [3:0] led;
  logic [5:0] level;
  logic       busy, win, lose;

  int     checks = 0;
  int     fails = 0;
  logic [15:0] m_lfsr;
  color_t exp_seq[$];
  color_t first_color;

  typedef struct packed {
    logic [1:0] kind;      // 0 correct colour, 1 wrong colour, 2 raw pattern
    logic [3:0] raw;
    logic       exp_lose;
    logic       exp_busy;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  genius_game_controller #(
    .MAX_LEN        (MAX_LEN),
    .LED_ON_CYCLES  (ON),
    .LED_OFF_CYCLES (OFF),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .btn_edge (btn_edge),
    .led      (led),
    .level    (level),
    .busy     (busy),
    .win      (win),
    .lose     (lose)
  );

  // Reference LFSR: right-shifting form, new MSB from bits 0,2,3,5.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= (m_lfsr >> 1) | {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], 15'b0};
  end

  function automatic logic [3:0] oh(input color_t c);
    logic [3:0] v;
    v = 4'b0000;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    btn_edge = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_seq.delete();
  endtask

  task automatic add_color();
    exp_seq.push_back(color_t'(m_lfsr[1:0]));
  endtask

  // Start a new game; returns during the ADD cycle.
  task automatic begin_game();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_seq.delete();
    add_color();
    check("add_level", 32'(level), 32'd0);
    check("add_busy", 32'(busy), 32'd1);
    check("add_win", 32'(win), 32'd0);
    check("add_lose", 32'(lose), 32'd0);
  endtask

  // From the ADD cycle, walk the playback; returns in the first WAIT_IN cycle.
  task automatic playback(input bit noise);
    color_t q[$];
    color_t c;
    q = exp_seq;
    step();
    check("show_level", 32'(level), 32'(exp_seq.size()));
    check("show_busy", 32'(busy), 32'd1);
    while (q.size() > 0) begin
      c = q.pop_front();
      for (int k = 0; k < int'(ON); k++) begin
        check("show_on_led", 32'(led), 32'(oh(c)));
        if (noise) btn_edge = 4'($urandom_range(1, 15));
        step();
      end
      for (int k = 0; k < int'(OFF); k++) begin
        check("show_off_led", 32'(led), 32'd0);
        if (noise) btn_edge = 4'($urandom_range(1, 15));
        step();
      end
    end
    btn_edge = 4'b0000;
    check("wait_led", 32'(led), 32'd0);
    check("wait_busy", 32'(busy), 32'd1);
    check("wait_lose", 32'(lose), 32'd0);
    check("wait_level", 32'(level), 32'(exp_seq.size()));
  endtask

  task automatic press(input color_t c);
    btn_edge = oh(c);
    step();
    btn_edge = 4'b0000;
  endtask

  // Replay the whole sequence correctly; ends in ADD (new colour queued) or WIN.
  task automatic replay();
    int l;
    l = exp_seq.size();
    for (int i = 0; i < l; i++) begin
      press(exp_seq[i]);
      check("replay_lose", 32'(lose), 32'd0);
      if (i < l - 1) check("replay_busy", 32'(busy), 32'd1);
    end
    check("replay_level", 32'(level), 32'(l));
    if (l < int'(MAX_LEN)) begin
      check("replay_add_led", 32'(led), 32'd0);
      add_color();
    end else begin
      check("win_flag", 32'(win), 32'd1);
      check("win_led", 32'(led), 32'hF);
      check("win_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] w;
    vecs[0] = '{2'd0, 4'h0, 1'b0, 1'b1};
    vecs[1] = '{2'd1, 4'h0, 1'b1, 1'b0};
    vecs[2] = '{2'd2, 4'h3, 1'b1, 1'b0};
    vecs[3] = '{2'd2, 4'hF, 1'b1, 1'b0};
    vecs[4] = '{2'd2, 4'hC, 1'b1, 1'b0};
    vecs[5] = '{2'd2, 4'h0, 1'b0, 1'b1};

    do_reset();
    check("rst_led", 32'(led), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_win", 32'(win), 32'd0);
    check("rst_lose", 32'(lose), 32'd0);

    // Full game to WIN.
    begin_game();
    first_color = exp_seq[0];
    repeat (MAX_LEN) begin
      playback(1'b0);
      replay();
    end
    step();
    check("win_hold", 32'(win), 32'd1);

    // New game from WIN, noisy playback at level 2, wrong second entry.
    begin_game();
    playback(1'b0);
    replay();
    playback(1'b1);
    press(exp_seq[0]);
    check("l2_first_ok", 32'(lose), 32'd0);
    w = 2'(exp_seq[1]) + 2'd1;
    press(color_t'(w));
    check("wrong_lose", 32'(lose), 32'd1);
    check("wrong_led", 32'(led), 32'd0);
    check("wrong_busy", 32'(busy), 32'd0);
    check("wrong_level", 32'(level), 32'd2);

    // Restart from LOSE, then timeout boundaries.
    begin_game();
    playback(1'b0);
    repeat (TO - 1) step();
    check("pre_timeout_lose", 32'(lose), 32'd0);
    press(exp_seq[0]);
    check("last_cycle_press_lose", 32'(lose), 32'd0);
    check("last_cycle_press_busy", 32'(busy), 32'd1);
    add_color();
    playback(1'b0);
    repeat (TO - 1) step();
    check("timeout_edge_lose", 32'(lose), 32'd0);
    step();
    check("timeout_lose", 32'(lose), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);

    // Single-entry press outcomes in WAIT_IN at level 1.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      begin_game();
      playback(1'b0);
      case (vecs[v].kind)
        2'd0:    btn_edge = oh(exp_seq[0]);
        2'd1: begin
          w = 2'(exp_seq[0]) + 2'd1;
          btn_edge = oh(color_t'(w));
        end
        default: btn_edge = vecs[v].raw;
      endcase
      step();
      btn_edge = 4'b0000;
      check($sformatf("vec%0d_lose", v), 32'(lose), 32'(vecs[v].exp_lose));
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
      check($sformatf("vec%0d_led", v), 32'(led), 32'd0);
      check($sformatf("vec%0d_level", v), 32'(level), 32'd1);
    end

    // Reset during SHOW_ON, then restart reproduces the first colour.
    do_reset();
    begin_game();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_led", 32'(led), 32'd0);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_win", 32'(win), 32'd0);
    check("midrst_lose", 32'(lose), 32'd0);
    do_reset();
    begin_game();
    step();
    check("restart_color", 32'(led), 32'(oh(first_color)));
    check("restart_level", 32'(level), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
